regfile_seq: RTL and testbench

Multi-cycle register-file access sequencer for the non-pipelined RV32I core. It is the initiator on the register-file port: it accepts one decoded instruction's register fields and reads rs1/rs2 through the register file's read-enable path. It then hands the operands to the execute stage, waits for the result, and writes it back to rd through the write-enable path. Only one instruction is in flight at a time.

---
 rtl/regfile_seq_if.sv | 60 ++++++
 rtl/regfile_seq.sv | 127 ++++++++++++
 tb/tb_regfile_seq.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_seq_if.sv
// Bundles the instruction, execute and register-file handshakes of regfile_seq.
// The sequencer drives through "master"; the decode/execute/register-file side
// connects through "slave".
interface regfile_seq_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    // Instruction intake from decode
    logic            instr_valid;
    logic            instr_ready;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic            uses_rs2;
    logic            writes_rd;
    // Operands toward execute
    logic            op_valid;
    logic            op_ready;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    // Result from execute
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] res_data;
    // Register-file port
    logic            rf_we;
    logic            rf_re;
    logic [AW-1:0]   rf_addr_a;
    logic [AW-1:0]   rf_addr_b;
    logic [XLEN-1:0] rf_wdata;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;
    // Status
    logic            busy;
    logic [31:0]     retired;

    modport master (
        input  instr_valid, rs1, rs2, rd, uses_rs2, writes_rd,
        output instr_ready,
        output op_valid, op_a, op_b,
        input  op_ready,
        input  res_valid, res_data,
        output res_ready,
        output rf_we, rf_re, rf_addr_a, rf_addr_b, rf_wdata,
        input  rf_rd1, rf_rd2,
        output busy, retired
    );

    modport slave (
        output instr_valid, rs1, rs2, rd, uses_rs2, writes_rd,
        input  instr_ready,
        input  op_valid, op_a, op_b,
        output op_ready,
        output res_valid, res_data,
        input  res_ready,
        input  rf_we, rf_re, rf_addr_a, rf_addr_b, rf_wdata,
        output rf_rd1, rf_rd2,
        input  busy, retired
    );
endinterface

// File: rtl/regfile_seq.sv
// Multi-cycle register-file access sequencer for the non-pipelined RV32I core.
// One instruction in flight: read rs1/rs2, hand operands to execute, wait for
// the result and write it back to rd (never to x0). All handshake and
// register-file strobes decode from the state register alone.
module regfile_seq #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_seq_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_ISSUE,
        S_WAIT_RES,
        S_WRITE
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [AW-1:0]   r_rs1;
    logic [AW-1:0]   r_rs2;
    logic [AW-1:0]   r_rd;
    logic            r_uses_rs2;
    logic            r_writes_rd;
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic [XLEN-1:0] r_result;
    logic [31:0]     r_retired;

    logic            w_accept;
    logic            w_op_fire;
    logic            w_res_fire;
    logic            w_retire;
    logic            w_rf_active;

    assign w_accept    = (r_state == S_IDLE)     && bus.instr_valid;
    assign w_op_fire   = (r_state == S_ISSUE)    && bus.op_ready;
    assign w_res_fire  = (r_state == S_WAIT_RES) && bus.res_valid;
    assign w_rf_active = (r_state == S_READ) || (r_state == S_CAPT);

    // An instruction retires on a non-writing op handshake, a result aimed at x0,
    // or the write-back cycle itself.
    assign w_retire = (w_op_fire && !r_writes_rd)
                    || (w_res_fire && (r_rd == '0))
                    || (r_state == S_WRITE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        // NOTE: default first so no path through this block can infer a latch.
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     if (bus.instr_valid) w_next = S_READ;
            S_READ:     w_next = S_CAPT;
            S_CAPT:     w_next = S_ISSUE;
            S_ISSUE:    if (bus.op_ready) w_next = r_writes_rd ? S_WAIT_RES : S_IDLE;
            S_WAIT_RES: if (bus.res_valid) w_next = (r_rd != '0) ? S_WRITE : S_IDLE;
            S_WRITE:    w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Instruction fields, operands, result and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_uses_rs2  <= 1'b0;
            r_writes_rd <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_result    <= '0;
            r_retired   <= '0;
        end else begin
            if (w_accept) begin
                r_rs1       <= bus.rs1;
                r_rs2       <= bus.rs2;
                r_rd        <= bus.rd;
                r_uses_rs2  <= bus.uses_rs2;
                r_writes_rd <= bus.writes_rd;
            end
            // Read data is sampled at the end of CAPT, a full cycle after the
            // addresses went out in READ. x0 reads as zero whatever the array holds.
            if (r_state == S_CAPT) begin
                r_op_a <= (r_rs1 == '0) ? '0 : bus.rf_rd1;
                r_op_b <= (!r_uses_rs2 || (r_rs2 == '0)) ? '0 : bus.rf_rd2;
            end
            if (w_res_fire) r_result <= bus.res_data;
            // Wraps naturally from all-ones to zero.
            r_retired <= r_retired + {31'b0, w_retire};
        end
    end

    // State decodes: no combinational path from inputs to any strobe
    assign bus.instr_ready = (r_state == S_IDLE);
    assign bus.op_valid    = (r_state == S_ISSUE);
    assign bus.res_ready   = (r_state == S_WAIT_RES);
    assign bus.rf_re       = w_rf_active;
    assign bus.rf_we       = (r_state == S_WRITE);
    assign bus.busy        = (r_state != S_IDLE);

    // Register-file address/data: rf_addr_a is rs1 while reading, rd while writing
    assign bus.rf_addr_a = w_rf_active            ? r_rs1
                         : (r_state == S_WRITE)   ? r_rd
                         : '0;
    assign bus.rf_addr_b = (w_rf_active && r_uses_rs2) ? r_rs2 : '0;
    assign bus.rf_wdata  = (r_state == S_WRITE) ? r_result : '0;

    assign bus.op_a    = r_op_a;
    assign bus.op_b    = r_op_b;
    assign bus.retired = r_retired;

endmodule

// File: tb/tb_regfile_seq.sv
// Directed bench for regfile_seq. Stimulus pushes expected operand handshakes
// and register-file writes into queues; a negedge monitor pops and compares
// whenever the DUT presents them. A behavioural register-file array answers
// the read port.
module tb_regfile_seq;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } pair_t;

    logic clk;
    logic rst_n;

    regfile_seq_if #(.XLEN(XLEN), .AW(AW)) bus ();

    regfile_seq #(.XLEN(XLEN), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: combinational read, written only by the stimulus
    logic [XLEN-1:0] rf_mem [32];
    assign bus.rf_rd1 = rf_mem[bus.rf_addr_a];
    assign bus.rf_rd2 = rf_mem[bus.rf_addr_b];

    int    n_checks = 0;
    int    n_errors = 0;
    pair_t exp_op_q [$];
    pair_t exp_wr_q [$];
    logic [31:0] exp_retired;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the scoreboard
    pair_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            check("we_re_exclusive", {31'b0, bus.rf_we & bus.rf_re}, 32'd0);
            if (bus.op_valid && bus.op_ready) begin
                if (exp_op_q.size() == 0) begin
                    check("unexpected_op_handshake", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_op_q.pop_front();
                    check("mon_op_a", bus.op_a, mon_e.a);
                    check("mon_op_b", bus.op_b, mon_e.b);
                end
            end
            if (bus.rf_we) begin
                if (exp_wr_q.size() == 0) begin
                    check("unexpected_rf_we", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_wr_q.pop_front();
                    check("mon_wr_addr", {27'b0, bus.rf_addr_a}, mon_e.a);
                    check("mon_wr_data", bus.rf_wdata, mon_e.b);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bus.instr_ready && n < 100) begin
            step();
            n++;
        end
        if (!bus.instr_ready) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    // One full instruction with optional operand stall and result delay
    task automatic run_instr(
        input logic [4:0]  rs1, input logic [4:0] rs2, input logic [4:0] rd,
        input logic        uses, input logic wr,
        input logic [31:0] exp_a, input logic [31:0] exp_b,
        input logic [31:0] result, input int stall, input int delay
    );
        pair_t e;
        wait_idle();
        bus.rs1 = rs1; bus.rs2 = rs2; bus.rd = rd;
        bus.uses_rs2 = uses; bus.writes_rd = wr;
        bus.instr_valid = 1'b1;
        e.a = exp_a; e.b = exp_b;
        exp_op_q.push_back(e);
        if (wr && rd != 5'd0) begin
            e.a = {27'b0, rd}; e.b = result;
            exp_wr_q.push_back(e);
        end
        step();                       // accept edge N
        bus.instr_valid = 1'b0;
        // cycle N+1: READ
        check("read_rf_re", {31'b0, bus.rf_re}, 32'd1);
        check("read_addr_a", {27'b0, bus.rf_addr_a}, {27'b0, rs1});
        check("read_addr_b", {27'b0, bus.rf_addr_b}, uses ? {27'b0, rs2} : 32'd0);
        check("read_busy", {31'b0, bus.busy}, 32'd1);
        step();
        // cycle N+2: CAPT
        check("capt_rf_re", {31'b0, bus.rf_re}, 32'd1);
        check("capt_op_valid", {31'b0, bus.op_valid}, 32'd0);
        step();
        // cycle N+3: ISSUE
        check("issue_op_valid", {31'b0, bus.op_valid}, 32'd1);
        check("issue_rf_re", {31'b0, bus.rf_re}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            bus.op_ready    = 1'b0;
            bus.instr_valid = 1'b1;          // must be ignored while busy
            bus.res_valid   = 1'b1;          // must be ignored outside WAIT_RES
            bus.res_data    = 32'hBAD0_0000 | i;
            check("stall_op_valid", {31'b0, bus.op_valid}, 32'd1);
            check("stall_op_a", bus.op_a, exp_a);
            check("stall_op_b", bus.op_b, exp_b);
            check("stall_instr_ready", {31'b0, bus.instr_ready}, 32'd0);
            check("stall_res_ready", {31'b0, bus.res_ready}, 32'd0);
            step();
        end
        bus.instr_valid = 1'b0;
        bus.res_valid   = 1'b0;
        bus.op_ready    = 1'b1;
        step();                       // operand handshake edge
        bus.op_ready = 1'b0;
        if (wr) begin
            for (int d = 0; d < delay; d++) begin
                check("wait_res_ready", {31'b0, bus.res_ready}, 32'd1);
                check("wait_op_valid", {31'b0, bus.op_valid}, 32'd0);
                step();
            end
            check("res_ready", {31'b0, bus.res_ready}, 32'd1);
            bus.res_valid = 1'b1;
            bus.res_data  = result;
            step();                   // result accepted at edge M
            bus.res_valid = 1'b0;
            if (rd != 5'd0) begin
                check("write_rf_we", {31'b0, bus.rf_we}, 32'd1);
                check("write_rf_re", {31'b0, bus.rf_re}, 32'd0);
                check("write_addr", {27'b0, bus.rf_addr_a}, {27'b0, rd});
                check("write_data", bus.rf_wdata, result);
                rf_mem[rd] = bus.rf_wdata;
                step();
            end
            check("done_rf_we", {31'b0, bus.rf_we}, 32'd0);
            check("done_instr_ready", {31'b0, bus.instr_ready}, 32'd1);
        end else begin
            check("store_res_ready", {31'b0, bus.res_ready}, 32'd0);
            check("store_instr_ready", {31'b0, bus.instr_ready}, 32'd1);
            check("store_busy", {31'b0, bus.busy}, 32'd0);
        end
        exp_retired = exp_retired + 32'd1;
        check("retired", bus.retired, exp_retired);
    endtask

    initial begin
        pair_t e;
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
        bus.instr_valid = 1'b0; bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0;
        bus.uses_rs2 = 1'b0; bus.writes_rd = 1'b0;
        bus.op_ready = 1'b0; bus.res_valid = 1'b0; bus.res_data = '0;
        exp_retired = 32'd0;
        rst_n = 1'b0;
        #1;
        // Reset state
        check("rst_instr_ready", {31'b0, bus.instr_ready}, 32'd1);
        check("rst_op_valid", {31'b0, bus.op_valid}, 32'd0);
        check("rst_res_ready", {31'b0, bus.res_ready}, 32'd0);
        check("rst_rf_we", {31'b0, bus.rf_we}, 32'd0);
        check("rst_rf_re", {31'b0, bus.rf_re}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_op_a", bus.op_a, 32'd0);
        check("rst_op_b", bus.op_b, 32'd0);
        check("rst_retired", bus.retired, 32'd0);
        check("rst_addr_a", {27'b0, bus.rf_addr_a}, 32'd0);
        check("rst_wdata", bus.rf_wdata, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Add x3 = x1 + x2
        rf_mem[1] = 32'd4;
        rf_mem[2] = 32'd1;
        run_instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'd4, 32'd1, 32'd5, 0, 0);

        // x0 handling: array x0 holds garbage, rd=0 discards the result
        rf_mem[0] = 32'hDEAD_BEEF;
        run_instr(5'd0, 5'd2, 5'd0, 1'b1, 1'b1, 32'd0, 32'd1, 32'h77, 0, 0);

        // Backpressure: operands stalled 5 cycles, result delayed 3
        run_instr(5'd3, 5'd1, 5'd4, 1'b1, 1'b1, 32'd5, 32'd4, 32'd9, 5, 3);

        // Store-like: no rs2 read even though rs2 field is nonzero, no write-back
        rf_mem[7] = 32'h0000_1234;
        run_instr(5'd4, 5'd7, 5'd9, 1'b0, 1'b0, 32'd9, 32'd0, 32'd0, 0, 0);

        // Reset while waiting for the result
        wait_idle();
        bus.rs1 = 5'd1; bus.rs2 = 5'd2; bus.rd = 5'd5;
        bus.uses_rs2 = 1'b1; bus.writes_rd = 1'b1;
        bus.instr_valid = 1'b1;
        e.a = 32'd4; e.b = 32'd1;
        exp_op_q.push_back(e);
        step();
        bus.instr_valid = 1'b0;
        step(); step();
        check("rwr_op_valid", {31'b0, bus.op_valid}, 32'd1);
        bus.op_ready = 1'b1;
        step();
        bus.op_ready = 1'b0;
        check("rwr_res_ready", {31'b0, bus.res_ready}, 32'd1);
        bus.res_valid = 1'b1;
        bus.res_data  = 32'h55;
        #2;
        rst_n = 1'b0;
        #1;
        check("rwr_async_res_ready", {31'b0, bus.res_ready}, 32'd0);
        check("rwr_async_rf_we", {31'b0, bus.rf_we}, 32'd0);
        check("rwr_async_instr_ready", {31'b0, bus.instr_ready}, 32'd1);
        check("rwr_async_busy", {31'b0, bus.busy}, 32'd0);
        check("rwr_async_op_a", bus.op_a, 32'd0);
        check("rwr_async_retired", bus.retired, 32'd0);
        step();
        bus.res_valid = 1'b0;
        rst_n = 1'b1;
        exp_retired = 32'd0;
        step();
        check("rwr_post_rf_we", {31'b0, bus.rf_we}, 32'd0);
        check("rwr_post_instr_ready", {31'b0, bus.instr_ready}, 32'd1);
        check("rwr_post_retired", bus.retired, 32'd0);
        check("rwr_x5_untouched", rf_mem[5], 32'd0);
        run_instr(5'd2, 5'd4, 5'd6, 1'b1, 1'b1, 32'd1, 32'd9, 32'h0A, 0, 1);

        // Counter wrap
        wait_idle();
        force dut.r_retired = 32'hFFFF_FFFF;
        step();
        release dut.r_retired;
        step();
        exp_retired = 32'hFFFF_FFFF;
        check("wrap_preload", bus.retired, exp_retired);
        run_instr(5'd6, 5'd0, 5'd7, 1'b1, 1'b1, 32'h0A, 32'd0, 32'h0B, 0, 0);
        check("wrap_zero", bus.retired, 32'd0);

        step(); step();
        check("op_queue_drained", exp_op_q.size(), 32'd0);
        check("wr_queue_drained", exp_wr_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
